usb_tx_pkt_ctrl: RTL and testbench

//  Sequences one USB transmit packet into the serial TX path (timer, PTS shift reg, bit stuffer, NRZI encoder).

---
 rtl/usb_tx_pkt_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_usb_tx_pkt_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_pkt_ctrl.sv
// USB TX packet sequencer: SYNC, PID, FIFO payload, CRC16, EOP; one byte handed over per load_enable strobe.
// Stalls indefinitely between strobes; an empty FIFO when a payload byte is due ends the packet with tx_error.
module usb_tx_pkt_ctrl #(
    parameter int          MAX_LEN    = 64,
    parameter int          EOP_CYCLES = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'h80,
    localparam int         LW         = $clog2(MAX_LEN + 1),
    localparam int         EW         = $clog2(EOP_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          tx_start,
    input  logic          tx_abort,
    input  logic [3:0]    tx_pid,
    input  logic [LW-1:0] tx_len,
    input  logic [7:0]    fifo_rdata,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    input  logic          load_enable,
    output logic          sending,
    output logic [7:0]    data,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          tx_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_PAYLOAD, S_CRC_LO, S_CRC_HI, S_DRAIN, S_EOP, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    pid, pid_nxt;
    logic [LW-1:0] len, len_nxt, cnt, cnt_nxt;
    logic [15:0]   crc, crc_nxt, crc_upd, crc_fin;
    logic [7:0]    crc_hi, crc_hi_nxt, data_nxt;
    logic [EW-1:0] eop_cnt, eop_nxt;
    logic          sending_nxt, done_nxt, error_nxt, go_eop, start_ok;

    // USB CRC16, reflected polynomial, one byte processed LSB first
    function automatic logic [15:0] crc8(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign tx_busy  = (state != S_IDLE);
    assign start_ok = (tx_pid[1:0] == 2'b10) ||
                      ((tx_pid[1:0] == 2'b11) && (tx_len <= LW'(MAX_LEN)));

    always_comb begin
        state_nxt   = state;
        sending_nxt = sending;
        data_nxt    = data;
        pid_nxt     = pid;
        len_nxt     = len;
        cnt_nxt     = cnt;
        crc_nxt     = crc;
        crc_hi_nxt  = crc_hi;
        eop_nxt     = eop_cnt;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        fifo_rd     = 1'b0;
        go_eop      = 1'b0;
        crc_upd     = crc8(crc, data);
        crc_fin     = ~crc_upd;
        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    if (!start_ok) begin
                        error_nxt = 1'b1;
                    end else begin
                        sending_nxt = 1'b1;
                        data_nxt    = SYNC_BYTE;
                        crc_nxt     = 16'hFFFF;
                        cnt_nxt     = '0;
                        pid_nxt     = tx_pid;
                        len_nxt     = tx_len;
                        state_nxt   = S_SYNC;
                    end
                end
            end
            S_EOP: begin
                if (eop_cnt == EW'(EOP_CYCLES - 1)) state_nxt = S_DONE;
                else                                eop_nxt   = eop_cnt + EW'(1);
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                if (tx_abort) begin
                    error_nxt = 1'b1;
                    go_eop    = 1'b1;
                end else if (load_enable) begin
                    case (state)
                        S_SYNC: begin
                            data_nxt  = {~pid, pid};
                            state_nxt = S_PID;
                        end
                        S_PID: begin
                            if (pid[1:0] == 2'b10) begin
                                state_nxt = S_DRAIN;
                            end else if (len == '0) begin
                                data_nxt   = 8'h00;
                                crc_hi_nxt = 8'h00;
                                state_nxt  = S_CRC_LO;
                            end else if (!fifo_empty) begin
                                fifo_rd   = 1'b1;
                                data_nxt  = fifo_rdata;
                                cnt_nxt   = LW'(1);
                                state_nxt = S_PAYLOAD;
                            end else begin
                                error_nxt = 1'b1;
                                go_eop    = 1'b1;
                            end
                        end
                        S_PAYLOAD: begin
                            crc_nxt = crc_upd;
                            if (cnt == len) begin
                                data_nxt   = crc_fin[7:0];
                                crc_hi_nxt = crc_fin[15:8];
                                state_nxt  = S_CRC_LO;
                            end else if (!fifo_empty) begin
                                fifo_rd  = 1'b1;
                                data_nxt = fifo_rdata;
                                cnt_nxt  = cnt + LW'(1);
                            end else begin
                                error_nxt = 1'b1;
                                go_eop    = 1'b1;
                            end
                        end
                        S_CRC_LO: begin
                            data_nxt  = crc_hi;
                            state_nxt = S_CRC_HI;
                        end
                        S_CRC_HI: state_nxt = S_DRAIN;
                        // this strobe means the final byte has left the shifter
                        S_DRAIN:  go_eop = 1'b1;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
        endcase
        if (go_eop) begin
            sending_nxt = 1'b0;
            eop_nxt     = '0;
            state_nxt   = S_EOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            sending  <= 1'b0;
            data     <= 8'h00;
            pid      <= 4'h0;
            len      <= '0;
            cnt      <= '0;
            crc      <= 16'hFFFF;
            crc_hi   <= 8'h00;
            eop_cnt  <= '0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            sending  <= sending_nxt;
            data     <= data_nxt;
            pid      <= pid_nxt;
            len      <= len_nxt;
            cnt      <= cnt_nxt;
            crc      <= crc_nxt;
            crc_hi   <= crc_hi_nxt;
            eop_cnt  <= eop_nxt;
            tx_done  <= done_nxt;
            tx_error <= error_nxt;
        end
    end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Directed bench for usb_tx_pkt_ctrl with a show-ahead FIFO model and a byte scoreboard.
module tb_usb_tx_pkt_ctrl;
    localparam int LW = $clog2(64 + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic          tx_start, tx_abort, load_enable, flush;
    logic [3:0]    tx_pid;
    logic [LW-1:0] tx_len;
    logic [7:0]    fifo_rdata, data;
    logic          fifo_empty, fifo_rd, sending, tx_busy, tx_done, tx_error;

    int tests = 0, failed = 0;
    int err_cnt = 0, done_cnt = 0, bad_rd = 0;
    int wr_ptr = 0, rd_ptr = 0;
    logic [7:0] mem [0:255];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    usb_tx_pkt_ctrl dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_abort(tx_abort),
        .tx_pid(tx_pid), .tx_len(tx_len), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .load_enable(load_enable), .sending(sending), .data(data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_rd && fifo_empty) bad_rd++;
        if (flush)        rd_ptr <= wr_ptr;
        else if (fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clk) begin
        if (tx_error) err_cnt++;
        if (tx_done)  done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic start_pkt(input logic [3:0] pid, input int len);
        tx_pid   = pid;
        tx_len   = LW'(len);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // two idle cycles, then one load_enable cycle; returns at the negedge after the strobe edge
    task automatic strobe(output logic [7:0] d);
        repeat (2) @(negedge clk);
        load_enable = 1'b1;
        #1;
        d = data;
        @(negedge clk);
        load_enable = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            strobe(d);
            if (exp_q.size() == 0) check("sb_empty", 32'(d), 32'hFFFF_FFFF);
            else                   check("load_byte", 32'(d), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic wait_done(input int exp_lat);
        int k;
        k = 0;
        while (!tx_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", 32'(k), 32'(exp_lat));
        @(negedge clk);
        check("done_width", 32'(tx_done), 32'd0);
        check("busy_after_done", 32'(tx_busy), 32'd0);
    endtask

    task automatic finish_pkt();
        logic [7:0] d;
        strobe(d);
        check("sending_drop", 32'(sending), 32'd0);
        wait_done(17);
    endtask

    initial begin
        int base, e0, d0;
        logic [15:0] c;
        logic [7:0]  b;
        n_rst = 1'b0; tx_start = 1'b0; tx_abort = 1'b0; load_enable = 1'b0; flush = 1'b0;
        tx_pid = 4'h0; tx_len = '0;
        repeat (3) @(negedge clk);
        check("rst_sending", 32'(sending), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // ACK with a second start issued while busy
        base = rd_ptr; e0 = err_cnt; d0 = done_cnt;
        start_pkt(4'h2, 0);
        check("ack_busy", 32'(tx_busy), 32'd1);
        check("ack_sending", 32'(sending), 32'd1);
        start_pkt(4'h3, 5);
        exp_q.push_back(8'h80); exp_q.push_back(8'hD2);
        send_bytes(2);
        finish_pkt();
        check("ack_pops", 32'(rd_ptr - base), 32'd0);
        check("ack_no_error", 32'(err_cnt - e0), 32'd0);
        check("ack_done_count", 32'(done_cnt - d0), 32'd1);

        // DATA0, empty payload
        base = rd_ptr; e0 = err_cnt; d0 = done_cnt;
        start_pkt(4'h3, 0);
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_bytes(4);
        finish_pkt();
        check("len0_pops", 32'(rd_ptr - base), 32'd0);
        check("len0_no_error", 32'(err_cnt - e0), 32'd0);
        check("len0_done_count", 32'(done_cnt - d0), 32'd1);

        // DATA1 "123456789", CRC 0xB4C8
        base = rd_ptr; e0 = err_cnt;
        for (int i = 0; i < 9; i++) push(8'h31 + 8'(i));
        start_pkt(4'hB, 9);
        exp_q.push_back(8'h80); exp_q.push_back(8'h4B);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
        send_bytes(13);
        finish_pkt();
        check("len9_pops", 32'(rd_ptr - base), 32'd9);
        check("len9_no_error", 32'(err_cnt - e0), 32'd0);

        // underflow: 4 bytes announced, 2 available
        base = rd_ptr; e0 = err_cnt;
        push(8'hAA); push(8'h55);
        start_pkt(4'h3, 4);
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3); exp_q.push_back(8'hAA);
        send_bytes(3);
        check("uf_sending_hold", 32'(sending), 32'd1);
        exp_q.push_back(8'h55);
        send_bytes(1);
        check("uf_sending_drop", 32'(sending), 32'd0);
        check("uf_error", 32'(tx_error), 32'd1);
        wait_done(17);
        check("uf_pops", 32'(rd_ptr - base), 32'd2);
        check("uf_error_count", 32'(err_cnt - e0), 32'd1);

        // abort coincident with a payload strobe
        base = rd_ptr;
        for (int i = 1; i <= 5; i++) push(8'(i));
        start_pkt(4'h3, 5);
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3); exp_q.push_back(8'h01);
        send_bytes(3);
        repeat (2) @(negedge clk);
        load_enable = 1'b1; tx_abort = 1'b1;
        #1;
        check("abort_no_pop", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        load_enable = 1'b0; tx_abort = 1'b0;
        check("abort_sending", 32'(sending), 32'd0);
        check("abort_error", 32'(tx_error), 32'd1);
        check("abort_pops", 32'(rd_ptr - base), 32'd2);
        wait_done(17);
        do_flush();

        // rejected starts
        start_pkt(4'h1, 0);
        check("bad_pid_error", 32'(tx_error), 32'd1);
        check("bad_pid_busy", 32'(tx_busy), 32'd0);
        start_pkt(4'h3, 65);
        check("bad_len_error", 32'(tx_error), 32'd1);
        check("bad_len_busy", 32'(tx_busy), 32'd0);

        // reset mid-payload
        for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i));
        start_pkt(4'hB, 3);
        exp_q.push_back(8'h80); exp_q.push_back(8'h4B); exp_q.push_back(8'hE0);
        send_bytes(3);
        n_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_sending", 32'(sending), 32'd0);
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_done", 32'(tx_done), 32'd0);
        check("mid_rst_error", 32'(tx_error), 32'd0);
        check("mid_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        n_rst = 1'b1;
        do_flush();

        // random payload checked against the bench CRC
        base = rd_ptr;
        c = 16'hFFFF;
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            exp_q.push_back(b);
            c = crc_step(c, b);
        end
        c = ~c;
        exp_q.push_back(c[7:0]); exp_q.push_back(c[15:8]);
        start_pkt(4'h3, 6);
        send_bytes(10);
        finish_pkt();
        check("rand_pops", 32'(rd_ptr - base), 32'd6);
        check("no_empty_pops", 32'(bad_rd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
